// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and default width.
package shift_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Parallel load / serial link / parallel capture signals of the shift sequencer.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = shift_seq_pkg::DEFAULT_WIDTH
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             serial_in;
  logic             serial_out;
  logic             serial_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             abort;

  // Producer/consumer side drives the requests and the serial input.
  modport master (
    output load_valid, load_data, serial_in, out_ready, abort,
    input  load_ready, serial_out, serial_en, out_valid, out_data
  );

  // Controller side.
  modport slave (
    input  load_valid, load_data, serial_in, out_ready, abort,
    output load_ready, serial_out, serial_en, out_valid, out_data
  );

endinterface

// File: rtl/shift_reg_datapath.sv
// WIDTH-bit parallel-load / serial-shift register bank with MSB tap.
module shift_reg_datapath
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic             msb,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], serial_in};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequences a parallel word out MSB-first over WIDTH cycles while capturing serial_in into out_data.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              reset,
  shift_seq_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             out_valid_nxt;
  logic             load_en, shift_en, capture;
  logic             msb;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;

  shift_reg_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .shift_en  (shift_en),
    .load_data (bus.load_data),
    .serial_in (bus.serial_in),
    .msb       (msb),
    .q         (shreg)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    out_valid_nxt = out_valid_q;
    load_en       = 1'b0;
    shift_en      = 1'b0;
    capture       = 1'b0;

    if (bus.abort) begin
      // Cancel wins over everything; register contents are kept.
      state_nxt     = IDLE;
      count_nxt     = '0;
      out_valid_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.load_valid) begin
            load_en   = 1'b1;
            count_nxt = '0;
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          shift_en = 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            capture       = 1'b1;
            out_valid_nxt = 1'b1;
            count_nxt     = '0;
            state_nxt     = HOLD;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_nxt = 1'b0;
            state_nxt     = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      out_valid_q <= out_valid_nxt;
      // Captured word equals the register's post-shift value on the final edge.
      if (capture) begin
        out_data_q <= {shreg[WIDTH-2:0], bus.serial_in};
      end
    end
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.serial_en  = (state == SHIFT);
  assign bus.serial_out = (state == SHIFT) ? msb : 1'b0;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench: directed scenarios plus randomized transfers against a transaction-level model.
module tb_shift_seq_ctrl;

  localparam int W = 8;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  // Model: last completed captured word (retained across aborts).
  logic [W-1:0] m_out_data;

  shift_seq_ctrl_if #(.WIDTH(W)) bus ();

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One load/shift/capture transaction.
  // abort_at: shift cycle index (0..W-1) carrying abort, or -1 for none.
  // exit_mode: 0 = release HOLD with out_ready, 1 = release HOLD with abort, 2 = stay in HOLD.
  task automatic transfer(input logic [W-1:0] d, input logic [W-1:0] sin, input bit loopback,
                          input int abort_at, input int bp, input int exit_mode);
    bit aborted = 0;
    @(negedge clk);
    check("idle_load_ready", {31'b0, bus.load_ready}, 32'd1);
    check("idle_serial_out", {31'b0, bus.serial_out}, 32'd0);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    for (int k = 0; k < W; k++) begin
      @(posedge clk); #1;
      // Producer may keep presenting new words during the shift; they must be ignored.
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.load_data  = W'($urandom);
      bus.serial_in  = loopback ? bus.serial_out : sin[W-1-k];
      bus.abort      = (k == abort_at);
      @(negedge clk);
      check("shift_serial_en", {31'b0, bus.serial_en}, 32'd1);
      check("shift_serial_out", {31'b0, bus.serial_out}, {31'b0, d[W-1-k]});
      check("shift_load_ready", {31'b0, bus.load_ready}, 32'd0);
      check("shift_out_valid", {31'b0, bus.out_valid}, 32'd0);
      if (k == abort_at) begin
        aborted = 1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.abort      = 1'b0;
    bus.load_valid = aborted ? 1'b0 : 1'($urandom_range(0, 1));
    bus.serial_in  = 1'($urandom);
    @(negedge clk);
    if (aborted) begin
      check("abort_serial_en", {31'b0, bus.serial_en}, 32'd0);
      check("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("abort_load_ready", {31'b0, bus.load_ready}, 32'd1);
      check("abort_out_data", {24'b0, bus.out_data}, {24'b0, m_out_data});
      return;
    end
    m_out_data = loopback ? d : sin;
    check("done_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("done_out_data", {24'b0, bus.out_data}, {24'b0, m_out_data});
    check("done_serial_en", {31'b0, bus.serial_en}, 32'd0);
    check("done_serial_out", {31'b0, bus.serial_out}, 32'd0);
    for (int b = 0; b < bp; b++) begin
      @(posedge clk); #1;
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.load_data  = W'($urandom);
      bus.out_ready  = 1'b0;
      @(negedge clk);
      check("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("hold_out_data", {24'b0, bus.out_data}, {24'b0, m_out_data});
      check("hold_load_ready", {31'b0, bus.load_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    if (exit_mode == 2) return;
    bus.out_ready = (exit_mode == 0);
    bus.abort     = (exit_mode == 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.abort     = 1'b0;
    @(negedge clk);
    check("exit_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("exit_load_ready", {31'b0, bus.load_ready}, 32'd1);
    check("exit_out_data", {24'b0, bus.out_data}, {24'b0, m_out_data});
  endtask

  initial begin
    m_out_data     = '0;
    reset          = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h5A;
    bus.serial_in  = 1'b1;
    bus.out_ready  = 1'b1;
    bus.abort      = 1'b0;

    // Reset held with arbitrary inputs, straddling a clock edge.
    #11;
    check("rst_load_ready", {31'b0, bus.load_ready}, 32'd1);
    check("rst_serial_en", {31'b0, bus.serial_en}, 32'd0);
    check("rst_serial_out", {31'b0, bus.serial_out}, 32'd0);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_data", {24'b0, bus.out_data}, 32'd0);
    #1;
    bus.load_valid = 1'b0;
    bus.out_ready  = 1'b0;
    reset          = 1'b1;

    // Loopback, independent capture, backpressure, abort mid-shift.
    transfer(8'hA5, 8'h00, 1'b1, -1, 0, 0);
    transfer(8'hFF, 8'h3A, 1'b0, -1, 0, 0);
    transfer(8'hC3, 8'h96, 1'b0, -1, 5, 0);
    transfer(8'h3C, 8'hE1, 1'b0, 3, 0, 0);
    transfer(8'h81, 8'h7E, 1'b0, -1, 2, 1);

    // Abort together with load_valid in IDLE: no load taken.
    @(posedge clk); #1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h99;
    bus.abort      = 1'b1;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    bus.abort      = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", {31'b0, bus.load_ready}, 32'd1);
    check("abort_idle_serial_en", {31'b0, bus.serial_en}, 32'd0);

    // Randomized transfers.
    for (int t = 0; t < 24; t++) begin
      logic [W-1:0] d, s;
      int ab, bp, ex;
      d  = W'($urandom);
      s  = W'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      bp = int'($urandom_range(0, 4));
      ex = ($urandom_range(0, 4) == 0) ? 1 : 0;
      transfer(d, s, 1'($urandom_range(0, 1)), ab, bp, ex);
    end

    // Asynchronous reset while in HOLD clears immediately.
    transfer(8'h5C, 8'hB7, 1'b0, -1, 1, 2);
    @(negedge clk);
    check("pre_rst_out_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    m_out_data = '0;
    check("async_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("async_rst_out_data", {24'b0, bus.out_data}, {24'b0, m_out_data});
    check("async_rst_load_ready", {31'b0, bus.load_ready}, 32'd1);
    @(negedge clk); #2;
    reset = 1'b1;

    transfer(8'h69, 8'h0F, 1'b0, -1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so a stuck design still reaches the summary.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
